// File: rtl/vga_scan_engine_if.sv
// ---------------------------------------------------------------------------
// vga_scan_engine_if
//
// Bundles the enable/frame-buffer/DAC signals of the VGA scan engine.
//
//   master modport (the scan engine):
//     in  enable       run scan; low = stopped and blanked
//     in  pix_data     {r,g,b} returned by the frame buffer
//     out rd_en        frame-buffer read strobe, one clk wide
//     out rd_addr      linear pixel address
//     out r, g, b      colour to DAC
//     out hsync/vsync  active-low syncs
//     out n_sync       DAC composite sync, constant 0
//     out n_blanc      DAC blank, low = blank
//     out n25MHZCLK    pixel clock to DAC
//     out frame_start  one-clk pulse at the first pixel of each frame
//     out frame_count  frames started, wraps
//   slave modport: the mirror image (frame buffer / DAC / controller side).
// ---------------------------------------------------------------------------
interface vga_scan_engine_if #(
   parameter int COLOR_W = 8,
   parameter int ADDR_W  = 19
);
   logic                   enable;
   logic [3*COLOR_W-1:0]   pix_data;
   logic                   rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic [COLOR_W-1:0]     r;
   logic [COLOR_W-1:0]     g;
   logic [COLOR_W-1:0]     b;
   logic                   hsync;
   logic                   vsync;
   logic                   n_sync;
   logic                   n_blanc;
   logic                   n25MHZCLK;
   logic                   frame_start;
   logic [15:0]            frame_count;

   modport master (
      input  enable, pix_data,
      output rd_en, rd_addr, r, g, b, hsync, vsync, n_sync, n_blanc,
             n25MHZCLK, frame_start, frame_count
   );

   modport slave (
      output enable, pix_data,
      input  rd_en, rd_addr, r, g, b, hsync, vsync, n_sync, n_blanc,
             n25MHZCLK, frame_start, frame_count
   );
endinterface

// File: rtl/vga_scan_engine.sv
// ---------------------------------------------------------------------------
// vga_scan_engine
//
// Parametrised VGA timing and pixel-fetch engine. A clock divider produces a
// pixel-clock enable (pix_ce); horizontal/vertical counters step on pix_ce;
// active pixels issue a one-clk read strobe with a linear address to the
// frame buffer. Raw sync/blank travel through an RD_LAT-deep delay line so
// that they meet the returned colour in the output register.
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   vga_scan_engine_if.master (enable, pix_data in; read strobe,
//         address, colour, syncs, blank, pixel clock, frame_start and
//         frame_count out)
// ---------------------------------------------------------------------------
module vga_scan_engine #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int RD_LAT   = 2,
   parameter int COLOR_W  = 8,
   parameter int ADDR_W   = 19
) (
   input  logic               clk,
   input  logic               rst,
   vga_scan_engine_if.master  bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
   localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
   localparam int DW      = $clog2(CLK_DIV);
   localparam int HS_LO   = H_ACTIVE + H_FP;
   localparam int HS_HI   = HS_LO + H_SYNC;
   localparam int VS_LO   = V_ACTIVE + V_FP;
   localparam int VS_HI   = VS_LO + V_SYNC;

   // Half-open window test used for both sync pulses.
   function automatic logic in_window(input int val, input int lo, input int hi);
      return (val >= lo) && (val < hi);
   endfunction

   logic [DW-1:0]       div_cnt;
   logic                pix_ce;
   logic                n25_clk;
   logic [HW-1:0]       hcnt;
   logic [VW-1:0]       vcnt;
   logic                h_last;
   logic                v_last;
   logic                frame_first;
   logic                frame_start;
   logic [15:0]         frame_count;
   logic                rd_en;
   logic [ADDR_W-1:0]   addr;

   logic                vld_p0;
   logic                hsync_p0;
   logic                vsync_p0;
   logic [RD_LAT-1:0]   vld_dly;
   logic [RD_LAT-1:0]   hsync_dly;
   logic [RD_LAT-1:0]   vsync_dly;
   logic                vld_p1;
   logic                hsync_p1;
   logic                vsync_p1;
   logic [COLOR_W-1:0]  r_p1;
   logic [COLOR_W-1:0]  g_p1;
   logic [COLOR_W-1:0]  b_p1;

   // ---- pixel clock divider ----
   // pix_ce already folds in enable, so everything downstream stops with it.
   assign pix_ce = bus.enable && (div_cnt == DW'(CLK_DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
         n25_clk <= 1'b0;
      end else if (!bus.enable) begin
         div_cnt <= '0;
         n25_clk <= 1'b0;
      end else begin
         n25_clk <= (int'(div_cnt) < CLK_DIV / 2);
         div_cnt <= pix_ce ? '0 : div_cnt + DW'(1);
      end
   end

   // ---- scan counters ----
   assign h_last      = (hcnt == HW'(H_TOTAL - 1));
   assign v_last      = (vcnt == VW'(V_TOTAL - 1));
   assign frame_first = (hcnt == '0) && (vcnt == '0);
   assign frame_start = pix_ce && frame_first;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (!bus.enable) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (pix_ce) begin
         if (h_last) begin
            hcnt <= '0;
            vcnt <= v_last ? '0 : vcnt + VW'(1);
         end else begin
            hcnt <= hcnt + HW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_count <= '0;
      end else if (frame_start) begin
         frame_count <= frame_count + 16'd1;
      end
   end

   // ---- stage p0: raw timing of the current pixel and the fetch ----
   assign vld_p0   = (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
   assign hsync_p0 = !in_window(int'(hcnt), HS_LO, HS_HI);
   assign vsync_p0 = !in_window(int'(vcnt), VS_LO, VS_HI);
   assign rd_en    = pix_ce && vld_p0;

   // The address counter is cleared on the last pixel of the frame, so the
   // very first read of the next frame (hcnt=0, vcnt=0) already presents 0.
   // That last pixel may itself be active when there are no porches; its
   // read still sees the final address before the clear takes effect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
      end else if (!bus.enable) begin
         addr <= '0;
      end else if (pix_ce && h_last && v_last) begin
         addr <= '0;
      end else if (rd_en) begin
         addr <= addr + ADDR_W'(1);
      end
   end

   // ---- delay line: RD_LAT pixel periods of sync/blank ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_dly   <= '0;
         hsync_dly <= '1;
         vsync_dly <= '1;
      end else if (!bus.enable) begin
         vld_dly   <= '0;
         hsync_dly <= '1;
         vsync_dly <= '1;
      end else if (pix_ce) begin
         vld_dly[0]   <= vld_p0;
         hsync_dly[0] <= hsync_p0;
         vsync_dly[0] <= vsync_p0;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_dly[i]   <= vld_dly[i-1];
            hsync_dly[i] <= hsync_dly[i-1];
            vsync_dly[i] <= vsync_dly[i-1];
         end
      end
   end

   // ---- stage p1: colour meets its delayed sync/blank ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         hsync_p1 <= 1'b1;
         vsync_p1 <= 1'b1;
         r_p1     <= '0;
         g_p1     <= '0;
         b_p1     <= '0;
      end else if (!bus.enable) begin
         vld_p1   <= 1'b0;
         hsync_p1 <= 1'b1;
         vsync_p1 <= 1'b1;
         r_p1     <= '0;
         g_p1     <= '0;
         b_p1     <= '0;
      end else if (pix_ce) begin
         vld_p1   <= vld_dly[RD_LAT-1];
         hsync_p1 <= hsync_dly[RD_LAT-1];
         vsync_p1 <= vsync_dly[RD_LAT-1];
         if (vld_dly[RD_LAT-1]) begin
            r_p1 <= bus.pix_data[3*COLOR_W-1:2*COLOR_W];
            g_p1 <= bus.pix_data[2*COLOR_W-1:COLOR_W];
            b_p1 <= bus.pix_data[COLOR_W-1:0];
         end else begin
            r_p1 <= '0;
            g_p1 <= '0;
            b_p1 <= '0;
         end
      end
   end

   assign bus.rd_en       = rd_en;
   assign bus.rd_addr     = addr;
   assign bus.r           = r_p1;
   assign bus.g           = g_p1;
   assign bus.b           = b_p1;
   assign bus.hsync       = hsync_p1;
   assign bus.vsync       = vsync_p1;
   assign bus.n_blanc     = vld_p1;
   assign bus.n_sync      = 1'b0;
   assign bus.n25MHZCLK   = n25_clk;
   assign bus.frame_start = frame_start;
   assign bus.frame_count = frame_count;

endmodule

// File: tb/tb_vga_scan_engine.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_engine
//
// Small-geometry bench: a 13x8 pixel frame (6x4 visible), four clocks per
// pixel and a two-pixel read latency. Expected behaviour is derived from the
// elapsed clock count since the scan last started; a frame-buffer model
// returns a hash of each read address exactly RD_LAT pixel periods later and
// drives random data in every other clock.
// ---------------------------------------------------------------------------
module tb_vga_scan_engine;

   localparam int HA = 6, HFP = 2, HSY = 3, HBP = 2;
   localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
   localparam int CD = 4, RL = 2, CW = 4, AW = 8;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FT = HT * VT;
   localparam int L  = RL * CD;
   localparam int PW = 3 * CW;

   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
      int   addr;
   } pix_t;

   logic clk = 1'b0;
   logic rst;

   vga_scan_engine_if #(.COLOR_W(CW), .ADDR_W(AW)) bus ();

   vga_scan_engine #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .CLK_DIV(CD), .RD_LAT(RL), .COLOR_W(CW), .ADDR_W(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] fb_word(input int a);
      return PW'(a * 37 + 11);
   endfunction

   function automatic pix_t pixel(input int p);
      pix_t x;
      int h, v;
      h = p % HT;
      v = (p / HT) % VT;
      x.act  = (h < HA) && (v < VA);
      x.hs   = !((h >= HA + HFP) && (h < HA + HFP + HSY));
      x.vs   = !((v >= VA + VFP) && (v < VA + VFP + VSY));
      x.addr = v * HA + h;
      return x;
   endfunction

   // scoreboard state
   bit running;
   int e;          // posedges since the scan last started
   int fc_base;    // frame_count at the moment the scan last started
   int g;          // global negedge index for the frame-buffer history
   bit hist_ok  [0:63];
   int hist_addr[0:63];

   function automatic int frames_seen(input int edges);
      int m;
      m = edges / CD;
      return (fc_base + (m + FT - 1) / FT) % 65536;
   endfunction

   task automatic clear_hist();
      for (int i = 0; i < 64; i++) begin
         hist_ok[i]   = 1'b0;
         hist_addr[i] = 0;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rd_en"},   32'(bus.rd_en), 32'd0);
      chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
      chk({tag, "_rgb"},     32'({bus.r, bus.g, bus.b}), 32'd0);
      chk({tag, "_hsync"},   32'(bus.hsync), 32'd1);
      chk({tag, "_vsync"},   32'(bus.vsync), 32'd1);
      chk({tag, "_n_blanc"}, 32'(bus.n_blanc), 32'd0);
      chk({tag, "_n_sync"},  32'(bus.n_sync), 32'd0);
      chk({tag, "_pixclk"},  32'(bus.n25MHZCLK), 32'd0);
      chk({tag, "_fstart"},  32'(bus.frame_start), 32'd0);
      chk({tag, "_fcount"},  32'(bus.frame_count), 32'd0);
   endtask

   task automatic check_outputs();
      pix_t cur, shown;
      int   m, q;
      bit   ce;
      chk("n_sync", 32'(bus.n_sync), 32'd0);
      if (!running) begin
         chk("idle_rd_en",   32'(bus.rd_en), 32'd0);
         chk("idle_rd_addr", 32'(bus.rd_addr), 32'd0);
         chk("idle_fstart",  32'(bus.frame_start), 32'd0);
         chk("idle_hsync",   32'(bus.hsync), 32'd1);
         chk("idle_vsync",   32'(bus.vsync), 32'd1);
         chk("idle_n_blanc", 32'(bus.n_blanc), 32'd0);
         chk("idle_rgb",     32'({bus.r, bus.g, bus.b}), 32'd0);
         chk("idle_fcount",  32'(bus.frame_count), 32'(fc_base));
      end else begin
         ce  = (e % CD == CD - 1);
         cur = pixel(e / CD);
         chk("rd_en", 32'(bus.rd_en), 32'(ce && cur.act));
         if (ce && cur.act) chk("rd_addr", 32'(bus.rd_addr), 32'(cur.addr));
         chk("frame_start", 32'(bus.frame_start), 32'(ce && ((e / CD) % FT == 0)));
         chk("pixclk", 32'(bus.n25MHZCLK), 32'(((e - 1) % CD) < CD / 2));
         chk("frame_count", 32'(bus.frame_count), 32'(frames_seen(e)));
         m = e / CD;
         q = m - 1 - RL;
         if (q >= 0) begin
            shown = pixel(q);
         end else begin
            shown.act = 1'b0; shown.hs = 1'b1; shown.vs = 1'b1; shown.addr = 0;
         end
         chk("hsync",   32'(bus.hsync), 32'(shown.hs));
         chk("vsync",   32'(bus.vsync), 32'(shown.vs));
         chk("n_blanc", 32'(bus.n_blanc), 32'(shown.act));
         chk("rgb", 32'({bus.r, bus.g, bus.b}), shown.act ? 32'(fb_word(shown.addr)) : 32'd0);
      end
   endtask

   initial begin
      int r;
      rst          = 1'b1;
      bus.enable   = 1'b0;
      bus.pix_data = '0;
      clear_hist();
      g = 0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst        = 1'b0;
      bus.enable = 1'b1;
      running    = 1'b1;
      e          = 0;
      fc_base    = 0;

      for (int it = 0; it < 8000; it++) begin
         @(negedge clk);
         if (running) e++;
         check_outputs();

         // frame buffer: remember this clock's read, return the one from L clocks ago
         hist_ok[g % 64]   = bus.rd_en;
         hist_addr[g % 64] = int'(bus.rd_addr);
         if (g >= L && hist_ok[(g - L) % 64])
            bus.pix_data = fb_word(hist_addr[(g - L) % 64]);
         else
            bus.pix_data = PW'($urandom);

         r = int'($urandom_range(0, 9999));
         if (it == 3000 || r < 3) begin
            g++;
            #2 rst = 1'b1;
            #1 check_reset("mid_rst");
            @(negedge clk);
            check_reset("rst_hold");
            rst     = 1'b0;
            running = bus.enable;
            e       = 0;
            fc_base = 0;
            clear_hist();
            bus.pix_data = PW'($urandom);
         end else if (running && (it == 1500 || r < 10)) begin
            hist_ok[g % 64] = 1'b0;
            fc_base    = frames_seen(e);
            bus.enable = 1'b0;
            running    = 1'b0;
            #1 chk("drop_rd_en", 32'(bus.rd_en), 32'd0);
         end else if (!running && r < 1500) begin
            bus.enable = 1'b1;
            running    = 1'b1;
            e          = 0;
         end
         g++;
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
- Parametrised VGA timing and pixel-fetch engine for the asip display path; successor to the fixed 640x480 output stage behind r/g/b, hsync, vsync, n_sync, n_blanc and n25MHZCLK.
- Generates the pixel-clock enable and the horizontal/vertical counters.
- Issues linear read requests to the vector-processor frame buffer and realigns the returned colour with delayed sync/blank, compensating a configurable read latency.
- Adds frame counting, a frame-start pulse and a run/stop control.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (>=2, even)
- RD_LAT, 2, frame-buffer read latency in pixel periods (>=1)
- COLOR_W, 8, bits per colour channel
- ADDR_W, 19, frame-buffer address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  run scan; low = stopped and blanked
- pix_data  in  3*COLOR_W  {r,g,b} returned by frame buffer
- rd_en  out  1  frame-buffer read strobe, one clk wide
- rd_addr  out  ADDR_W  linear pixel address
- r, g, b  out  COLOR_W each  colour to DAC
- hsync, vsync  out  1  active-low syncs
- n_sync  out  1  DAC composite sync, constant 0
- n_blanc  out  1  DAC blank, low = blank
- n25MHZCLK  out  1  pixel clock to DAC
- frame_start  out  1  one-clk pulse at first pixel of each frame
- frame_count  out  16  frames started, wraps

Behaviour:
- Reset (async) values: all counters 0; rd_en=0; rd_addr=0; r=g=b=0; hsync=vsync=1; n_blanc=0; n_sync=0; n25MHZCLK=0; frame_start=0; frame_count=0; pipeline cleared.
- Divider: div_cnt counts 0..CLK_DIV-1 every clk. pix_ce is high when div_cnt==CLK_DIV-1. n25MHZCLK registered high while div_cnt < CLK_DIV/2.
- Counters advance only on pix_ce:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters.
  - When hcnt wraps, vcnt advances 0..V_TOTAL-1, wrapping to 0.
- Active window: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Raw syncs:
  - hsync low for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low for the equivalent range on vcnt.
- Fetch: rd_en = pix_ce & enable & active.
  - rd_addr is an incremental counter, never a multiply.
  - It presents the address of the current rd_en, then increments after each rd_en.
  - It resets to 0 on the pix_ce at hcnt=0, vcnt=0.
  - Last address per frame is H_ACTIVE*V_ACTIVE-1.
- Alignment: raw hsync, vsync and active pass through an RD_LAT-deep shift register clocked by pix_ce.
  - On the pix_ce RD_LAT pixels after a read, pix_data is sampled into r/g/b together with the delayed syncs and n_blanc = delayed active.
  - When delayed active=0, r=g=b=0.
- frame_start: pulses on the pix_ce where hcnt=0 and vcnt=0 while enable=1. frame_count increments in the same clk, wrapping 0xFFFF to 0.
- enable low:
  - Clears div_cnt, hcnt, vcnt, rd_addr and the pipeline synchronously on the next clk.
  - Holds rd_en=0, hsync=vsync=1, n_blanc=0, r=g=b=0. frame_count is held.
  - On re-assertion the scan restarts from hcnt=0, vcnt=0; the first pix_ce raises frame_start.
- Mid-operation reset: immediate return to reset values; no partial-frame state survives.
- Simultaneous hcnt wrap and vcnt wrap on the same pix_ce: both counters go to 0, rd_addr goes to 0 and frame_start fires in that cycle.

Test Plan:
- Defaults, enable=1 after reset: hsync low 192 clk per line; line period 1600 clk; vsync low 2 lines = 3200 clk; frame period 840000 clk.
- Defaults, full frame: exactly 307200 rd_en pulses per frame; rd_addr runs 0..307199 then returns to 0; frame_start is one clk wide; frame_count goes 0->1->2 over two frames.
- H_ACTIVE=4, V_ACTIVE=2, small porches, RD_LAT=2, pix_data = rd_addr pattern: r/g/b show address k exactly 2 pixel periods after rd_en for k; colour is 0 and n_blanc=0 outside active.
- enable dropped mid-line at hcnt=100: within 1 clk rd_en=0, n_blanc=0, hsync=1. On re-enable, first rd_addr=0, frame_start pulses and frame_count increments once.
- rst asserted mid-frame asynchronously: outputs take reset values in the same cycle; frame_count=0; scan restarts from the top after release.
- CLK_DIV=4: n25MHZCLK high 2 clk, low 2 clk; line period 3200 clk.
